axis_video_pattern_gen: RTL and testbench

// - AXI4-Stream video source placed directly upstream of the frame-capture sink in the hist-eq simulation chain.
// - Emits HEIGHT x WIDTH frames of N-bit pixels as tdata, tvalid, tlast (end of line) and tuser (start of frame).
// - Provides known pixel statistics for histogram-equalization stimulus; synthesizable, so it doubles as an on-chip test source.

---
 rtl/hist_eq_pkg.sv | 22 ++
 rtl/pattern_lfsr.sv | 29 ++
 rtl/axis_video_pattern_gen.sv | 184 ++++++++++++++++++
 tb/tb_axis_video_pattern_gen.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/hist_eq_pkg.sv
// Shared types for the hist-eq video chain: pattern modes, generator FSM states
// and the LFSR seed used by the pattern source.
package hist_eq_pkg;

    typedef enum logic [2:0] {
        MODE_RAMP_H  = 3'd0,
        MODE_RAMP_V  = 3'd1,
        MODE_CHECKER = 3'd2,
        MODE_CONST   = 3'd3,
        MODE_LFSR    = 3'd4
    } pattern_mode_t;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        HBLANK,
        VBLANK
    } pg_state_t;

    localparam logic [15:0] LFSR_SEED = 16'h0001;

endpackage

// File: rtl/pattern_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) with step and reseed controls.
// next_o exposes the post-step value so the caller can present it in the same cycle.
module pattern_lfsr
    import hist_eq_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        step_i,
    input  logic        reseed_i,
    output logic [15:0] state_o,
    output logic [15:0] next_o
);

    logic [15:0] lfsr_q;

    assign next_o  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign state_o = lfsr_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q <= LFSR_SEED;
        end else if (reseed_i) begin
            lfsr_q <= LFSR_SEED;
        end else if (step_i) begin
            lfsr_q <= next_o;
        end
    end

endmodule

// File: rtl/axis_video_pattern_gen.sv
// AXI4-Stream video test-pattern source (ramps, checker, constant) with line/frame blanking.
// Define PATTERN_GEN_LFSR_EN to add the pseudo-random MODE_LFSR pattern.
module axis_video_pattern_gen
    import hist_eq_pkg::*;
#(
    parameter int N        = 8,
    parameter int HEIGHT   = 355,
    parameter int WIDTH    = 355,
    parameter int H_BLANK  = 4,
    parameter int V_BLANK  = 16,
    parameter int CHK_LOG2 = 4
) (
    input  logic           i_sys_clk,
    input  logic           i_sys_areset,
    input  logic           i_start,
    input  logic           i_continuous,
    input  logic [2:0]     i_mode,
    input  logic [N-1:0]   i_const_value,
    input  logic           i_video_tready,
    output logic [N-1:0]   o_video_tdata,
    output logic           o_video_tvalid,
    output logic           o_video_tlast,
    output logic           o_video_tuser,
    output logic           o_busy,
    output logic [15:0]    o_frame_cnt
);

    localparam int XW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int YW        = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int BLANK_TOT = H_BLANK + V_BLANK;
    localparam int BW        = (BLANK_TOT > 1) ? $clog2(BLANK_TOT) : 1;

    pg_state_t     state_q;
    pattern_mode_t mode_q;
    logic [N-1:0]  const_q;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [BW-1:0] blank_q;
    logic [15:0]   frame_cnt_q;
    logic [N-1:0]  tdata_q;
    logic          tvalid_q, tlast_q, tuser_q;

    logic          acc, eol, eof, start_frame;
    logic [N-1:0]  pix_start, pix_next, pix_resume;

    function automatic logic [N-1:0] pixel_f(input pattern_mode_t m, input logic [N-1:0] c,
                                             input logic [31:0] px, input logic [31:0] py);
        case (m)
            MODE_RAMP_V:  pixel_f = py[N-1:0];
            MODE_CHECKER: pixel_f = (px[CHK_LOG2] ^ py[CHK_LOG2]) ? {N{1'b1}} : {N{1'b0}};
            MODE_CONST:   pixel_f = c;
            default:      pixel_f = px[N-1:0];
        endcase
    endfunction

    always_comb begin
        acc = tvalid_q & i_video_tready;
        eol = (x_q == XW'(WIDTH - 1));
        eof = eol & (y_q == YW'(HEIGHT - 1));
        x_d = eol ? '0 : x_q + XW'(1);
        y_d = eol ? (eof ? '0 : y_q + YW'(1)) : y_q;
        // A frame starts from IDLE, after VBLANK, or back-to-back when there is no blanking at all
        case (state_q)
            IDLE:    start_frame = i_start;
            ACTIVE:  start_frame = acc & eof & (BLANK_TOT == 0) & i_continuous;
            VBLANK:  start_frame = (blank_q == '0) & i_continuous;
            default: start_frame = 1'b0;
        endcase
    end

`ifdef PATTERN_GEN_LFSR_EN
    logic [15:0] lfsr_state, lfsr_next;

    pattern_lfsr u_lfsr (
        .clk_i    (i_sys_clk),
        .rst_i    (i_sys_areset),
        .step_i   (acc),
        .reseed_i (start_frame),
        .state_o  (lfsr_state),
        .next_o   (lfsr_next)
    );
`endif

    always_comb begin
        pix_start  = pixel_f(pattern_mode_t'(i_mode), i_const_value, '0, '0);
        pix_next   = pixel_f(mode_q, const_q, 32'(x_d), 32'(y_d));
        pix_resume = pixel_f(mode_q, const_q, 32'(x_q), 32'(y_q));
`ifdef PATTERN_GEN_LFSR_EN
        if (pattern_mode_t'(i_mode) == MODE_LFSR) begin
            pix_start = LFSR_SEED[N-1:0];
        end
        if (mode_q == MODE_LFSR) begin
            pix_next   = lfsr_next[N-1:0];
            pix_resume = lfsr_state[N-1:0];
        end
`endif
    end

    always_ff @(posedge i_sys_clk or posedge i_sys_areset) begin
        if (i_sys_areset) begin
            state_q     <= IDLE;
            mode_q      <= MODE_RAMP_H;
            const_q     <= '0;
            x_q         <= '0;
            y_q         <= '0;
            blank_q     <= '0;
            frame_cnt_q <= '0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tuser_q     <= 1'b0;
        end else begin
            case (state_q)
                ACTIVE: begin
                    if (acc) begin
                        x_q <= x_d;
                        y_q <= y_d;
                        if (eof) begin
                            frame_cnt_q <= frame_cnt_q + 16'd1;
                        end
                        if (eof || (eol && H_BLANK != 0)) begin
                            tvalid_q <= 1'b0;
                            tdata_q  <= '0;
                            tlast_q  <= 1'b0;
                            tuser_q  <= 1'b0;
                            if (eof && BLANK_TOT == 0) begin
                                state_q <= IDLE;
                            end else if (eof) begin
                                state_q <= VBLANK;
                                blank_q <= BW'(BLANK_TOT - 1);
                            end else begin
                                state_q <= HBLANK;
                                blank_q <= BW'(H_BLANK - 1);
                            end
                        end else begin
                            tdata_q <= pix_next;
                            tlast_q <= (x_d == XW'(WIDTH - 1));
                            tuser_q <= 1'b0;
                        end
                    end
                end
                HBLANK: begin
                    if (blank_q == '0) begin
                        state_q  <= ACTIVE;
                        tvalid_q <= 1'b1;
                        tdata_q  <= pix_resume;
                        tlast_q  <= eol;
                        tuser_q  <= 1'b0;
                    end else begin
                        blank_q <= blank_q - BW'(1);
                    end
                end
                VBLANK: begin
                    if (blank_q == '0) begin
                        state_q <= IDLE;
                    end else begin
                        blank_q <= blank_q - BW'(1);
                    end
                end
                default: ;
            endcase
            // Frame start overrides whatever the branch above decided
            if (start_frame) begin
                state_q  <= ACTIVE;
                mode_q   <= pattern_mode_t'(i_mode);
                const_q  <= i_const_value;
                x_q      <= '0;
                y_q      <= '0;
                tvalid_q <= 1'b1;
                tdata_q  <= pix_start;
                tlast_q  <= (WIDTH == 1);
                tuser_q  <= 1'b1;
            end
        end
    end

    assign o_video_tdata  = tdata_q;
    assign o_video_tvalid = tvalid_q;
    assign o_video_tlast  = tlast_q;
    assign o_video_tuser  = tuser_q;
    assign o_busy         = (state_q != IDLE);
    assign o_frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_axis_video_pattern_gen.sv
// Directed bench: three small generator configurations sharing one clock and reset.
module tb_axis_video_pattern_gen;
    import hist_eq_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_v = 1'b0;
    logic        rdy = 1'b1;
    logic        cont = 1'b0;
    logic [2:0]  mode = 3'd0;
    logic [7:0]  cval = 8'd0;
    int          sel = 0;

    logic [7:0]  td [3];
    logic        tv [3];
    logic        tl [3];
    logic        tu [3];
    logic        bz [3];
    logic [15:0] fc [3];

    logic [7:0]  cap_d [512];
    logic        cap_l [512];
    logic        cap_u [512];
    int          cap_gap [512];
    int          ncap = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    // A: 4x2 no blanking
    axis_video_pattern_gen #(.N(8), .HEIGHT(2), .WIDTH(4), .H_BLANK(0), .V_BLANK(0), .CHK_LOG2(4)) u_a (
        .i_sys_clk(clk), .i_sys_areset(rst), .i_start(start_v && sel == 0), .i_continuous(cont),
        .i_mode(mode), .i_const_value(cval), .i_video_tready(rdy),
        .o_video_tdata(td[0]), .o_video_tvalid(tv[0]), .o_video_tlast(tl[0]), .o_video_tuser(tu[0]),
        .o_busy(bz[0]), .o_frame_cnt(fc[0]));

    // B: 4x2 with 4/16 blanking
    axis_video_pattern_gen #(.N(8), .HEIGHT(2), .WIDTH(4), .H_BLANK(4), .V_BLANK(16), .CHK_LOG2(4)) u_b (
        .i_sys_clk(clk), .i_sys_areset(rst), .i_start(start_v && sel == 1), .i_continuous(cont),
        .i_mode(mode), .i_const_value(cval), .i_video_tready(rdy),
        .o_video_tdata(td[1]), .o_video_tvalid(tv[1]), .o_video_tlast(tl[1]), .o_video_tuser(tu[1]),
        .o_busy(bz[1]), .o_frame_cnt(fc[1]));

    // C: 20x20 for checker squares of 16
    axis_video_pattern_gen #(.N(8), .HEIGHT(20), .WIDTH(20), .H_BLANK(0), .V_BLANK(0), .CHK_LOG2(4)) u_c (
        .i_sys_clk(clk), .i_sys_areset(rst), .i_start(start_v && sel == 2), .i_continuous(cont),
        .i_mode(mode), .i_const_value(cval), .i_video_tready(rdy),
        .o_video_tdata(td[2]), .o_video_tvalid(tv[2]), .o_video_tlast(tl[2]), .o_video_tuser(tu[2]),
        .o_busy(bz[2]), .o_frame_cnt(fc[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Collects accepted beats of the selected instance; optional 3-cycle stall on beat stall_at (value 2)
    task automatic capture(input int nbeats, input int max_cycles, input int stall_at);
        int idle = 0;
        int stalled = 0;
        int cyc = 0;
        ncap = 0;
        while (ncap < nbeats && cyc < max_cycles) begin
            @(negedge clk);
            start_v = 1'b0;
            cyc++;
            if (ncap == stall_at && stalled < 3 && tv[sel]) begin
                rdy = 1'b0;
                stalled++;
                check("stall_valid", 32'(tv[sel]), 32'd1);
                check("stall_data", 32'(td[sel]), 32'd2);
            end else begin
                rdy = 1'b1;
            end
            if (tv[sel] && rdy) begin
                cap_d[ncap]   = td[sel];
                cap_l[ncap]   = tl[sel];
                cap_u[ncap]   = tu[sel];
                cap_gap[ncap] = idle;
                idle = 0;
                ncap++;
            end else if (!tv[sel]) begin
                idle++;
            end
        end
        check("beat_count", ncap, nbeats);
        if (stall_at >= 0) check("stall_cycles", stalled, 3);
    endtask

    task automatic wait_idle(input int max_cycles);
        int cyc = 0;
        while (bz[sel] && cyc < max_cycles) begin
            @(negedge clk);
            cyc++;
        end
        check("busy_fall", 32'(bz[sel]), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_tvalid", 32'(tv[0]), 32'd0);
        check("rst_tdata", 32'(td[0]), 32'd0);
        check("rst_busy", 32'(bz[1]), 32'd0);
        check("rst_fcnt", 32'(fc[2]), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Ramp H, single frame, no stall
        sel = 0; mode = 3'd0; cont = 1'b0; start_v = 1'b1;
        capture(8, 40, -1);
        check("first_latency", cap_gap[0], 0);
        for (int i = 0; i < 8; i++) begin
            check("ramph_data", 32'(cap_d[i]), i % 4);
            check("ramph_user", 32'(cap_u[i]), 32'(i == 0));
            check("ramph_last", 32'(cap_l[i]), 32'((i % 4) == 3));
        end
        @(negedge clk);
        check("ramph_fcnt", 32'(fc[0]), 32'd1);
        check("ramph_busy", 32'(bz[0]), 32'd0);

        // Ramp H with back-pressure on beat 2
        start_v = 1'b1;
        capture(8, 40, 2);
        for (int i = 0; i < 8; i++) check("stall_seq", 32'(cap_d[i]), i % 4);
        @(negedge clk);
        check("stall_fcnt", 32'(fc[0]), 32'd2);

        // Constant value
        mode = 3'd3; cval = 8'hA5; start_v = 1'b1;
        capture(8, 40, -1);
        mode = 3'd1; cval = 8'h00;   // mid-frame change must not matter
        for (int i = 0; i < 8; i++) check("const_data", 32'(cap_d[i]), 32'hA5);
        @(negedge clk);

        // Unsupported code falls back to ramp H
        mode = 3'd7; start_v = 1'b1;
        capture(8, 40, -1);
        for (int i = 0; i < 8; i++) check("mode7_data", 32'(cap_d[i]), i % 4);
        @(negedge clk);

        // LFSR code: ramp H unless the feature is built in
        mode = 3'd4; start_v = 1'b1;
        capture(8, 40, -1);
        for (int i = 0; i < 8; i++) begin
`ifdef PATTERN_GEN_LFSR_EN
            check("lfsr_data", 32'(cap_d[i]), 32'(1 << i));
`else
            check("lfsr_fallback", 32'(cap_d[i]), i % 4);
`endif
        end
        @(negedge clk);
        check("a_fcnt", 32'(fc[0]), 32'd5);

        // Blanking and continuous mode, ramp V
        sel = 1; mode = 3'd1; cont = 1'b1; start_v = 1'b1;
        capture(16, 200, -1);
        cont = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check("blank_data", 32'(cap_d[i]), (i % 8) / 4);
            check("blank_user", 32'(cap_u[i]), 32'((i % 8) == 0));
            check("blank_last", 32'(cap_l[i]), 32'((i % 4) == 3));
            check("blank_gap", cap_gap[i], (i == 0) ? 0 : ((i % 8) == 0) ? 20 : ((i % 4) == 0) ? 4 : 0);
        end
        wait_idle(60);
        check("blank_fcnt", 32'(fc[1]), 32'd2);

        // Checker frame
        sel = 2; mode = 3'd2; start_v = 1'b1;
        capture(400, 600, -1);
        check("chk_0_0", 32'(cap_d[0]), 32'h00);
        check("chk_15_0", 32'(cap_d[15]), 32'h00);
        check("chk_16_0", 32'(cap_d[16]), 32'hFF);
        check("chk_0_16", 32'(cap_d[320]), 32'hFF);
        check("chk_16_16", 32'(cap_d[336]), 32'h00);
        check("chk_last19", 32'(cap_l[19]), 32'd1);
        check("chk_last399", 32'(cap_l[399]), 32'd1);
        @(negedge clk);
        check("chk_fcnt", 32'(fc[2]), 32'd1);

        // Reset mid-frame, then restart
        start_v = 1'b1;
        capture(150, 300, -1);
        rst = 1'b1;
        #1;
        check("mrst_tvalid", 32'(tv[2]), 32'd0);
        check("mrst_tdata", 32'(td[2]), 32'd0);
        check("mrst_tuser", 32'(tu[2]), 32'd0);
        check("mrst_busy", 32'(bz[2]), 32'd0);
        check("mrst_fcnt", 32'(fc[2]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mrst_no_resume", 32'(tv[2]), 32'd0);
        start_v = 1'b1;
        capture(17, 40, -1);
        check("restart_user", 32'(cap_u[0]), 32'd1);
        check("restart_data", 32'(cap_d[0]), 32'h00);
        check("restart_x16", 32'(cap_d[16]), 32'hFF);
        check("restart_latency", cap_gap[0], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
